// File: rtl/regbank_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_wr_arbiter
//
// Shares the register bank's single write port between NREQ writeback
// requesters (0 = ALU, 1 = load, 2 = SP/PC unit). A round-robin arbiter picks
// one valid requester per cycle. The winning request is captured in a
// registered output stage, so the bank sees write/dr/wrData one cycle after
// the grant. While a write sits in that output stage, the bank still holds the
// old value, so reads of the same register are flagged as hazards.
//
// Handshake: a requester raises req_valid[i] and holds req_valid, req_dr and
// req_data stable. The transfer completes on a clock edge where both
// req_valid[i] and req_ready[i] are 1. After that edge, the requester may drop
// valid or present its next request.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req_valid[NREQ]     per-requester write request
//   req_dr[NREQ*AW]     per-requester destination, slice i*AW +: AW
//   req_data[NREQ*DW]   per-requester data, slice i*DW +: DW
//   req_ready[NREQ]     one-hot grant (combinational)
//   write, dr, wrData   registered bank write port
//   sr1, sr2            bank read addresses, mirrored for hazard detection
//   haz1, haz2          read address matches the pending output-stage write
//   err, err_id         sticky out-of-range destination flag, first offender
//   wr_count            saturating count of issued bank writes
// ---------------------------------------------------------------------------
module regbank_wr_arbiter #(
  parameter int NREQ  = 3,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int NREGS = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_dr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              write,
  output logic [AW-1:0]     dr,
  output logic [DW-1:0]     wrData,
  input  logic [AW-1:0]     sr1,
  input  logic [AW-1:0]     sr2,
  output logic              haz1,
  output logic              haz2,
  output logic              err,
  output logic [1:0]        err_id,
  output logic [15:0]       wr_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          write_q;
  logic [AW-1:0] dr_q;
  logic [DW-1:0] wr_data_q;
  logic          err_q;
  logic [1:0]    err_id_q;
  logic [15:0]   wr_count_q;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   sel_idx;
  logic            found;
  int              idx;
  logic [AW-1:0]   sel_dr;
  logic [DW-1:0]   sel_data;
  logic            hs;
  logic            dr_ok;

  // Round-robin search: first valid index at or after rr_ptr, wrapping.
  always_comb begin
    grant   = '0;
    sel_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        sel_idx    = PW'(idx);
      end
    end
    // No handshake may complete while reset is held.
    if (reset) grant = '0;
  end

  assign req_ready = grant;
  assign hs        = |(req_valid & grant);
  assign sel_dr    = req_dr[int'(sel_idx)*AW +: AW];
  assign sel_data  = req_data[int'(sel_idx)*DW +: DW];
  assign dr_ok     = ({1'b0, sel_dr} < NREGS_W);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) begin
      if (int'(sel_idx) == NREQ - 1) rr_ptr_d = '0;
      else                           rr_ptr_d = sel_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      write_q    <= 1'b0;
      dr_q       <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      err_id_q   <= '0;
      wr_count_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      // Out-of-range destinations still complete the handshake but never
      // reach the bank; dr/wrData keep their last issued values.
      write_q  <= hs && dr_ok;
      if (hs && dr_ok) begin
        dr_q      <= sel_dr;
        wr_data_q <= sel_data;
      end
      // Only the first bad request is recorded.
      if (hs && !dr_ok && !err_q) begin
        err_q    <= 1'b1;
        err_id_q <= 2'(sel_idx);
      end
      if (write_q && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign write    = write_q;
  assign dr       = dr_q;
  assign wrData   = wr_data_q;
  assign err      = err_q;
  assign err_id   = err_id_q;
  assign wr_count = wr_count_q;

  // The bank still holds the old value while the write is in the output stage.
  assign haz1 = !reset && write_q && (sr1 == dr_q);
  assign haz2 = !reset && write_q && (sr2 == dr_q);

endmodule

// File: doc/regbank_wr_arbiter.md
Name: regbank_wr_arbiter

Overview:
- Shares the register bank's single write port (write, dr, wrData) between NREQ writeback requesters: ALU writeback, load writeback, and SP/PC update.
- Round-robin arbitration with a valid/ready handshake.
- The output stage is registered, so the bank write lands on the edge after the grant.
- Flags read-after-write hazards for the bank's two asynchronous read ports while a granted write is still in the output stage.

Parameters:
NREQ, 3, number of requesters (index 0 = ALU, 1 = load, 2 = SP/PC unit)
AW, 5, register address width
DW, 32, data width
NREGS, 18, number of valid registers (R0-R15, SP = 16, PC = 17)

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester write request
req_dr  input  NREQ*AW  per-requester destination; requester i uses bits [i*AW +: AW]
req_data  input  NREQ*DW  per-requester write data; requester i uses bits [i*DW +: DW]
req_ready  output  NREQ  one-hot grant; combinational from req_valid and the rr pointer
write  output  1  registered write enable to the register bank
dr  output  AW  registered destination to the register bank
wrData  output  DW  registered write data to the register bank
sr1  input  AW  read address 1, mirrored from the bank's read port
sr2  input  AW  read address 2, mirrored from the bank's read port
haz1  output  1  sr1 matches a write pending in the output stage
haz2  output  1  sr2 matches a write pending in the output stage
err  output  1  sticky: a request targeted dr >= NREGS
err_id  output  2  requester index of the first bad request
wr_count  output  16  number of writes issued to the bank; saturates at 16'hFFFF

Behaviour:
- Reset values: write=0, dr=0, wrData=0, rr_ptr=0, err=0, err_id=0, wr_count=0.
  - req_ready, haz1 and haz2 are 0 during reset regardless of inputs.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ; the first set bit is granted.
  - req_ready is one-hot, or zero if no request is valid.
  - A handshake completes on a cycle where req_valid[i] and req_ready[i] are both 1.
- Requester rule: once req_valid[i] rises, req_valid[i], req_dr and req_data stay stable until the handshake completes.
  - The bench checks this; the block does not.
- Pointer update:
  - On a handshake with requester k, rr_ptr <= (k+1) mod NREQ.
  - With no handshake, rr_ptr holds.
  - Starvation bound: a continuously valid requester is granted within NREQ cycles.
- Output stage (1-cycle latency):
  - On a handshake with a valid destination (dr < NREGS): write <= 1, dr <= req_dr[k], wrData <= req_data[k].
  - Otherwise write <= 0, with dr and wrData holding their previous values.
  - Back-to-back grants produce write=1 on consecutive cycles.
  - The bank commits the write on the following edge.
- Invalid destination (req_dr[k] >= NREGS):
  - The handshake still completes, so the requester is not stalled.
  - No bank write is issued: write <= 0.
  - If err=0: err <= 1 and err_id <= k. Later bad requests do not change err_id.
  - err clears only on reset.
- Hazards (combinational):
  - haz1 = write && (sr1 == dr); haz2 = write && (sr2 == dr).
  - Reads during the output-stage cycle see the old bank value; the consumer stalls while the flag is high.
- wr_count increments by 1 on each cycle where write=1 and holds at 16'hFFFF.
- Reset asserted mid-operation:
  - A write already in the output stage is dropped: write <= 0 on the reset edge.
  - No handshake completes while reset=1.
  - rr_ptr returns to 0.
- Simultaneous events:
  - All NREQ requesters valid: exactly one is granted per cycle.
  - Two requesters targeting the same dr in successive grants: both writes are issued in grant order, so the last one granted wins.
- No combinational path from req_valid to write, dr or wrData.

Test Plan:
1. Reset, then req_valid=3'b001, req_dr[0]=5, req_data[0]=32'hA5A5_0001 -> req_ready=3'b001 that cycle; next cycle write=1, dr=5, wrData=32'hA5A5_0001, haz1=1 when sr1=5; wr_count=1 after that cycle.
2. req_valid=3'b111 held for 6 cycles, rr_ptr=0 -> grant order 0,1,2,0,1,2; write=1 on 6 consecutive cycles; dr follows each requester's req_dr.
3. req_valid[1]=1 with req_dr[1]=5'd20 -> handshake completes, write stays 0, err=1, err_id=1; a later bad request from requester 2 leaves err_id=1.
4. Grant to requester 2 with dr=16 (SP), then assert reset on the next cycle -> write=0 after the reset edge, rr_ptr=0, wr_count=0, err=0.
5. Requester 0 writes R3=1 then R3=2 on consecutive grants while requesters 1 and 2 are idle -> two consecutive writes to dr=3; final bank R3=2.
6. Requester 0 continuously valid with requesters 1 and 2 toggling randomly for 1000 cycles -> requester 0 is never denied more than 2 consecutive cycles; wr_count equals the number of valid-destination handshakes.
